// File: rtl/seq_pkg.sv
// Shared types and helpers for the programmable output sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_pattern_table.sv
// Step table: pattern/dwell register array, one write port, combinational read.
module seq_pattern_table
  import seq_pkg::*;
#(
  parameter  int unsigned N_OUT   = 4,
  parameter  int unsigned N_STEPS = 4,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned IDX_W   = idx_w(N_STEPS)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [N_OUT-1:0]   wr_pattern,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [N_OUT-1:0]   rd_pattern,
  output logic [DWELL_W-1:0] rd_dwell
);

  logic [N_OUT-1:0]   pat_mem   [N_STEPS];
  logic [DWELL_W-1:0] dwell_mem [N_STEPS];

  // No reset: table contents survive rst and abort.
  always_ff @(posedge clk) begin
    if (we && (32'(wr_addr) < N_STEPS)) begin
      pat_mem[wr_addr]   <= wr_pattern;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  assign rd_pattern = pat_mem[rd_idx];
  assign rd_dwell   = dwell_mem[rd_idx];

endmodule

// File: rtl/seq_pattern_ctrl.sv
// Programmable multi-channel output sequencer: steps through a pattern table,
// holding each entry for dwell+1 cycles, then finishes or wraps.
module seq_pattern_ctrl
  import seq_pkg::*;
#(
  parameter  int unsigned N_OUT   = 4,
  parameter  int unsigned N_STEPS = 4,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned IDX_W   = idx_w(N_STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [N_OUT-1:0]   cfg_pattern,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [N_OUT-1:0]   outs,
  output logic               active,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   step_idx
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic               last;
  logic [IDX_W-1:0]   rd_idx;
  logic [N_OUT-1:0]   rd_pattern;
  logic [DWELL_W-1:0] rd_dwell;

  assign last = (step_idx == IDX_W'(N_STEPS - 1));

  // Single read port: it always addresses the entry loaded at the next
  // reload, i.e. step 0 when starting or wrapping, else step_idx+1.
  always_comb begin
    rd_idx = '0;
    if (state == RUN && !last) rd_idx = step_idx + IDX_W'(1);
  end

  seq_pattern_table #(
    .N_OUT   (N_OUT),
    .N_STEPS (N_STEPS),
    .DWELL_W (DWELL_W)
  ) u_table (
    .clk        (clk),
    .we         (cfg_we & ~busy),
    .wr_addr    (cfg_addr),
    .wr_pattern (cfg_pattern),
    .wr_dwell   (cfg_dwell),
    .rd_idx     (rd_idx),
    .rd_pattern (rd_pattern),
    .rd_dwell   (rd_dwell)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      outs     <= '0;
      active   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        outs     <= '0;
        active   <= 1'b0;
        busy     <= 1'b0;
        step_idx <= '0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE, FINISH: begin
            if (start) begin
              state    <= RUN;
              step_idx <= '0;
              outs     <= rd_pattern;
              cnt      <= rd_dwell;
              busy     <= 1'b1;
              active   <= 1'b0;
            end
          end
          RUN: begin
            if (cnt != '0) begin
              cnt <= cnt - DWELL_W'(1);
            end else if (!last || loop_en) begin
              step_idx <= rd_idx;
              outs     <= rd_pattern;
              cnt      <= rd_dwell;
            end else begin
              state  <= FINISH;
              busy   <= 1'b0;
              active <= 1'b1;
              done   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Scoreboard bench for seq_pattern_ctrl: a time-since-start reference model
// queues expected outputs each cycle; a monitor pops and compares after each edge.
module tb_seq_pattern_ctrl;

  localparam int unsigned N_OUT   = 4;
  localparam int unsigned N_STEPS = 4;
  localparam int unsigned DWELL_W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         loop_en = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [3:0]   cfg_pattern = '0;
  logic [7:0]   cfg_dwell = '0;
  logic [3:0]   outs;
  logic         active, busy, done;
  logic [1:0]   step_idx;

  seq_pattern_ctrl #(
    .N_OUT   (N_OUT),
    .N_STEPS (N_STEPS),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .loop_en     (loop_en),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_pattern (cfg_pattern),
    .cfg_dwell   (cfg_dwell),
    .outs        (outs),
    .active      (active),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] outs;
    logic       active;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Reference model: a run is described by cycles elapsed since its start.
  logic [3:0]  tp [N_STEPS];
  int unsigned td [N_STEPS];
  bit          m_run = 0, m_act = 0, m_done = 0;
  logic [3:0]  m_outs = '0;
  int unsigned m_idx = 0;
  int unsigned run_t = 0;

  function automatic int unsigned total_len();
    int unsigned s = 0;
    for (int k = 0; k < int'(N_STEPS); k++) s += td[k] + 1;
    return s;
  endfunction

  function automatic int unsigned step_of(input int unsigned t);
    int unsigned acc = 0;
    for (int k = 0; k < int'(N_STEPS); k++) begin
      acc += td[k] + 1;
      if (t < acc) return k;
    end
    return N_STEPS - 1;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit a, input bit l,
                     input bit we, input int unsigned ad,
                     input logic [3:0] p, input int unsigned d);
    bit   was_busy;
    obs_t e;
    @(negedge clk);
    rst = r; start = s; abort = a; loop_en = l;
    cfg_we = we; cfg_addr = 2'(ad); cfg_pattern = p; cfg_dwell = 8'(d);
    was_busy = m_run;
    if (r) begin
      m_run = 0; m_act = 0; m_done = 0; m_outs = '0; m_idx = 0;
    end else begin
      m_done = 0;
      if (a) begin
        m_run = 0; m_act = 0; m_outs = '0; m_idx = 0;
      end else if (!m_run && s) begin
        m_run = 1; m_act = 0; run_t = 0;
      end else if (m_run) begin
        run_t++;
        if (run_t == total_len()) begin
          if (l) run_t = 0;
          else begin
            m_run = 0; m_act = 1; m_done = 1;
          end
        end
      end
      if (m_run) begin
        m_idx  = step_of(run_t);
        m_outs = tp[m_idx];
      end
      if (we && !was_busy && ad < N_STEPS) begin
        tp[ad] = p;
        td[ad] = d;
      end
    end
    e.outs = m_outs; e.active = m_act; e.busy = m_run;
    e.done = m_done; e.idx = 2'(m_idx);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit l);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, l, 0, 0, '0, 0);
  endtask

  task automatic run_hold(input int n, input bit s, input bit l);
    for (int i = 0; i < n; i++) cyc(0, s, 0, l, 0, 0, '0, 0);
  endtask

  task automatic prog_default();
    cyc(0, 0, 0, 0, 1, 0, 4'b1000, 0);
    cyc(0, 0, 0, 0, 1, 1, 4'b0100, 1);
    cyc(0, 0, 0, 0, 1, 2, 4'b0010, 2);
    cyc(0, 0, 0, 0, 1, 3, 4'b0001, 3);
  endtask

  always @(posedge clk) begin : monitor
    obs_t e;
    obs_t g;
    #1;
    cyc_no++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = {outs, active, busy, done, step_idx};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL obs cycle %0d: outs=%b active=%b busy=%b done=%b idx=%0d, expected outs=%b active=%b busy=%b done=%b idx=%0d",
                 cyc_no, g.outs, g.active, g.busy, g.done, g.idx,
                 e.outs, e.active, e.busy, e.done, e.idx);
      end
    end
  end

  initial begin
    // Reset and program the reference table.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, '0, 0);
    idle(2, 0);
    prog_default();
    idle(2, 0);

    // Single run: 1+2+3+4 cycles, then done and hold.
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    idle(14, 0);

    // Loop mode over three full loops, then abort.
    cyc(0, 1, 0, 1, 0, 0, '0, 0);
    idle(32, 1);
    cyc(0, 0, 1, 1, 0, 0, '0, 0);
    idle(2, 0);

    // Abort during step 2, then replay from step 0.
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    idle(4, 0);
    cyc(0, 0, 1, 0, 0, 0, '0, 0);
    idle(2, 0);
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    idle(12, 0);

    // Write while busy is ignored; the same write in FINISH takes effect.
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 0, 1, 1, 4'b1111, 1);
    idle(11, 0);
    cyc(0, 0, 0, 0, 1, 1, 4'b1111, 1);
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    idle(12, 0);

    // start held high: no retrigger while busy, instant restart in FINISH.
    run_hold(25, 1, 0);
    idle(3, 0);

    // rst together with abort and start mid-step; table survives.
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    idle(4, 0);
    cyc(1, 1, 1, 0, 0, 0, '0, 0);
    idle(2, 0);
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    idle(12, 0);

    // Maximum dwell on one step, dwell 0 elsewhere.
    prog_default();
    cyc(0, 0, 0, 0, 1, 2, 4'b0110, 255);
    cyc(0, 1, 0, 0, 0, 0, '0, 0);
    idle(270, 0);

    // Randomized traffic.
    begin
      bit l = 0;
      for (int i = 0; i < 2000; i++) begin
        bit r, s, a, we;
        r  = ($urandom_range(0, 199) == 0);
        s  = ($urandom_range(0, 7) == 0);
        a  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 15) == 0) l = ~l;
        we = !r && !s && ($urandom_range(0, 5) == 0);
        cyc(r, s, a, l, we, $urandom_range(0, 3), 4'($urandom),
            ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 6));
      end
    end
    idle(3, 0);

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_ctrl.md
Name: seq_pattern_ctrl

Overview:
Programmable multi-channel output sequencer, the parametrised successor of the team's fixed 4-step output sequencer. It steps through a table of up to N_STEPS output patterns, holding each for a programmable dwell time. After the last step it raises `active`, or wraps to step 0 in loop mode. It sits between the control/config logic and the actuator or enable lines it drives.

Parameters:
N_OUT, 4, number of output channels (pattern width)
N_STEPS, 4, table depth (number of steps), must be >= 2
DWELL_W, 8, width of per-step dwell counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a sequence (level sampled each edge)
abort  in  1  cancel the running sequence
loop_en  in  1  1 = wrap to step 0 after the last step instead of finishing
cfg_we  in  1  table write strobe
cfg_addr  in  clog2(N_STEPS)  table entry index
cfg_pattern  in  N_OUT  output pattern for that entry
cfg_dwell  in  DWELL_W  dwell for that entry; step lasts cfg_dwell+1 cycles
outs  out  N_OUT  registered channel outputs
active  out  1  sequence completed; held until restart, abort or reset
busy  out  1  sequence running
done  out  1  one-cycle pulse on completion
step_idx  out  clog2(N_STEPS)  current step index

Behaviour:
- Reset: sync, active-high, on clk only. State=IDLE; outs=0, active=0, busy=0, done=0, step_idx=0, dwell counter=0. Table contents are NOT cleared; all table entries read 0 only after an explicit write.
- Table write: when cfg_we=1 and busy=0, entry cfg_addr <= {cfg_pattern, cfg_dwell} at the edge. Writes while busy=1 are ignored. A cfg_addr >= N_STEPS is ignored.
- FSM states: IDLE, RUN, FINISH.
- IDLE → RUN: on an edge with start=1 and abort=0. At that edge: step_idx<=0, outs<=pattern[0], cnt<=dwell[0], busy<=1, active<=0.
- RUN, cnt != 0: cnt <= cnt-1; all outputs hold.
- RUN, cnt == 0, step_idx < N_STEPS-1: step_idx++, outs<=pattern[step_idx+1], cnt<=dwell[step_idx+1].
- RUN, cnt == 0, last step, loop_en=1: wrap to step 0 and reload pattern[0]/dwell[0]. No done pulse, active stays 0.
- RUN, cnt == 0, last step, loop_en=0: go to FINISH. busy<=0, active<=1, done<=1 for exactly one cycle. outs hold the last pattern.
- Latency: step k is visible on outs for exactly dwell[k]+1 cycles. active rises sum_k(dwell[k]+1) cycles after the start edge.
- FINISH: active and outs held. start=1 restarts the sequence exactly as from IDLE, with active<=0 at that edge.
- start while busy=1 is ignored.
- abort=1 at any edge (not in reset): state<=IDLE, outs<=0, busy<=0, active<=0, done<=0, step_idx<=0. abort has priority over start and over step advance.
- Simultaneous events: rst beats abort, abort beats start, and start in FINISH beats hold.
- Reset mid-sequence: identical to reset from any state.
- loop_en is sampled only at the last-step boundary; changing it mid-step has no other effect.
- dwell=0 gives a 1-cycle step. dwell=2^DWELL_W-1 gives the maximum step length with no overflow.

Decomposition:
- Shared package seq_pkg: state enum (IDLE, RUN, FINISH) and a helper function for the index width (clog2).
- One natural sub-module, seq_pattern_table: a register array with write port (cfg_*) and combinational read port (index → pattern, dwell). The FSM, counter and output registers stay in the top module.

Test Plan:
Run with N_OUT=4, N_STEPS=4, DWELL_W=8.
- Reset, then program patterns {1000,0100,0010,0001} with dwells {0,1,2,3}, then pulse start → outs show 1000 for 1 cycle, 0100 for 2, 0010 for 3, 0001 for 4; done pulses once; active=1 at 10 cycles after the start edge; outs hold 0001.
- Same table with loop_en=1 → pattern repeats every 10 cycles with step_idx 0,1,2,3,0…; done never pulses; active stays 0 over 3 full loops.
- abort asserted in step 2 (outs=0010) → next cycle outs=0000, busy=0, active=0, step_idx=0. A following start replays from step 0.
- cfg_we to entry 1 with pattern 1111 while busy → ignored, and step 1 still shows 0100. The same write in FINISH → accepted, and the next run shows 1111 at step 1.
- start held high continuously → no re-trigger while busy; immediate restart on the first edge in FINISH, and active drops at that edge.
- rst asserted mid-step together with abort and start → all outputs 0 and state IDLE next cycle; table contents are retained (a re-run reproduces the prior pattern).
